// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient} to execute.
// Optional early-out for |dividend| < |divisor| is enabled by defining DIV_EARLY_OUT_EN.
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_sign_i,
    input  logic [DATA_W-1:0]     div_reg1_i,
    input  logic [DATA_W-1:0]     div_reg2_i,
    input  logic                  div_start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   div_res_o,
    output logic                  div_done_o,
    output logic [1:0]            div_state_o
);

    // Handshake: execute holds div_start_i high until it sees div_done_o; dropping it
    // in END clears the result and frees the unit. Requests are taken only in FREE.
    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [2*DATA_W:0]     r_work, w_work_nxt;
    logic [DATA_W-1:0]     r_divisor, w_divisor_nxt;
    logic [DATA_W-1:0]     r_dividend, w_dividend_nxt;
    logic                  r_dvd_neg, w_dvd_neg_nxt;
    logic                  r_dvs_neg, w_dvs_neg_nxt;
    logic                  r_early, w_early_nxt;
    logic [2*DATA_W-1:0]   r_res, w_res_nxt;
    logic                  r_done, w_done_nxt;

    logic                  w_dvd_neg, w_dvs_neg, w_early;
    logic [DATA_W-1:0]     w_dvd_abs, w_dvs_abs;
    logic [DATA_W:0]       w_diff;
    logic [DATA_W-1:0]     w_quot, w_rem;

    assign w_dvd_neg = div_sign_i & div_reg1_i[DATA_W-1];
    assign w_dvs_neg = div_sign_i & div_reg2_i[DATA_W-1];
    assign w_dvd_abs = w_dvd_neg ? (DATA_W'(0) - div_reg1_i) : div_reg1_i;
    assign w_dvs_abs = w_dvs_neg ? (DATA_W'(0) - div_reg2_i) : div_reg2_i;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_dvd_abs < w_dvs_abs);
`else
    assign w_early = 1'b0;
`endif

    assign w_diff = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};
    assign w_quot = (r_dvd_neg ^ r_dvs_neg) ? (DATA_W'(0) - r_work[DATA_W-1:0])
                                            : r_work[DATA_W-1:0];
    assign w_rem  = r_dvd_neg ? (DATA_W'(0) - r_work[2*DATA_W:DATA_W+1])
                              : r_work[2*DATA_W:DATA_W+1];

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_work_nxt     = r_work;
        w_divisor_nxt  = r_divisor;
        w_dividend_nxt = r_dividend;
        w_dvd_neg_nxt  = r_dvd_neg;
        w_dvs_neg_nxt  = r_dvs_neg;
        w_early_nxt    = r_early;
        w_res_nxt      = r_res;
        w_done_nxt     = r_done;
        case (r_state)
            S_FREE: begin
                if (div_start_i && !annul_i) begin
                    w_dividend_nxt = div_reg1_i;
                    w_divisor_nxt  = w_dvs_abs;
                    w_dvd_neg_nxt  = w_dvd_neg;
                    w_dvs_neg_nxt  = w_dvs_neg;
                    w_cnt_nxt      = '0;
                    w_work_nxt     = {{DATA_W{1'b0}}, w_dvd_abs, 1'b0};
                    w_early_nxt    = 1'b0;
                    if (div_reg2_i == '0) begin
                        w_state_nxt = S_BYZERO;
                    end else if (w_early) begin
                        // Early-out shares the BYZERO slot so its done timing matches.
                        w_early_nxt = 1'b1;
                        w_state_nxt = S_BYZERO;
                    end else begin
                        w_state_nxt = S_ON;
                    end
                end
            end
            S_BYZERO: begin
                w_work_nxt  = '0;
                w_res_nxt   = r_early ? {r_dividend, {DATA_W{1'b0}}} : '0;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FREE;
                end else if (r_cnt != CNT_W'(DATA_W)) begin
                    if (w_diff[DATA_W]) begin
                        w_work_nxt = {r_work[2*DATA_W-1:0], 1'b0};
                    end else begin
                        w_work_nxt = {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_res_nxt   = {w_rem, w_quot};
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_END;
                end
            end
            S_END: begin
                if (!div_start_i) begin
                    w_done_nxt  = 1'b0;
                    w_res_nxt   = '0;
                    w_state_nxt = S_FREE;
                end
            end
            default: w_state_nxt = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FREE;
            r_cnt      <= '0;
            r_work     <= '0;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_dvd_neg  <= 1'b0;
            r_dvs_neg  <= 1'b0;
            r_early    <= 1'b0;
            r_res      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_work     <= w_work_nxt;
            r_divisor  <= w_divisor_nxt;
            r_dividend <= w_dividend_nxt;
            r_dvd_neg  <= w_dvd_neg_nxt;
            r_dvs_neg  <= w_dvs_neg_nxt;
            r_early    <= w_early_nxt;
            r_res      <= w_res_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign div_res_o   = r_res;
    assign div_done_o  = r_done;
    assign div_state_o = r_state;

endmodule
